// File: rtl/z3_master_cycle_pkg.sv
// Shared state encodings and transfer-size codes for the Zorro III bus-master cycle generator.
package z3_master_cycle_pkg;

   typedef enum logic [2:0] {
      Z3M_IDLE    = 3'd0,
      Z3M_ADDR    = 3'd1,
      Z3M_FCS     = 3'd2,
      Z3M_DATA    = 3'd3,
      Z3M_WAIT    = 3'd4,
      Z3M_TERM    = 3'd5,
      Z3M_ABORT   = 3'd6,
      Z3M_RECOVER = 3'd7
   } z3m_state_t;

   localparam logic [1:0] SIZ_LONG  = 2'b00;
   localparam logic [1:0] SIZ_BYTE  = 2'b01;
   localparam logic [1:0] SIZ_WORD  = 2'b10;
   localparam logic [1:0] SIZ_3BYTE = 2'b11;

   // NCR size code to byte count; long (00) means four bytes.
   function automatic logic [2:0] siz_bytes(input logic [1:0] siz);
      siz_bytes = (siz == SIZ_LONG) ? 3'd4 : {1'b0, siz};
   endfunction

endpackage

// File: rtl/z3_lane_decode.sv
// Combinational byte-lane decode: NCR size and low address bits to active-low Zorro data strobes.
module z3_lane_decode
   import z3_master_cycle_pkg::*;
(
   input  logic [1:0] siz,
   input  logic [1:0] addr_lo,
   output logic [3:0] ds_mask_n
);

   logic [2:0] first_lane;
   logic [2:0] last_raw;
   logic [2:0] last_lane;

   // Lanes run from the start offset up to the end of the longword; offset 0 is ZDS_n[3].
   always_comb begin
      first_lane = {1'b0, addr_lo};
      last_raw   = first_lane + siz_bytes(siz) - 3'd1;
      last_lane  = (last_raw > 3'd3) ? 3'd3 : last_raw;
      ds_mask_n  = 4'hF;
      for (int k = 0; k < 4; k++) begin
         if (3'(k) >= first_lane && 3'(k) <= last_lane) begin
            ds_mask_n[3 - k] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle generator: turns each NCR 53C710 master request into one Z3 cycle
// once the arbiter has granted the bus.
module z3_master_cycle
   import z3_master_cycle_pkg::*;
#(
   parameter int ADDR_SETUP  = 1,
   parameter int TIMEOUT     = 255,
   parameter int SYNC_STAGES = 2
)(
   input  logic       CLK,
   input  logic       RST,
   input  logic       BMASTER,
   input  logic       NCR_AS_n,
   input  logic       NCR_READ,
   input  logic [1:0] NCR_SIZ,
   input  logic [1:0] NCR_A,
   input  logic       DTACK_n,
   input  logic       BERR_n,
   output logic       ADDR_OE,
   output logic       ZFCS_n,
   output logic       ZREAD,
   output logic       ZDOE,
   output logic [3:0] ZDS_n,
   output logic       NCR_STERM_n,
   output logic       NCR_BERR_n,
   output logic       busy
);

   z3m_state_t state, state_next;

   logic                   lat_read;
   logic [1:0]             lat_siz;
   logic [1:0]             lat_a;
   logic [3:0]             lane_mask_n;
   logic [SYNC_STAGES-1:0] dtack_sync;
   logic [SYNC_STAGES-1:0] berr_sync;
   logic                   dtack_s_n;
   logic                   berr_s_n;
   logic [1:0]             setup_cnt;
   logic [7:0]             wait_cnt;
   logic                   start;

   assign start     = BMASTER && !NCR_AS_n;
   assign dtack_s_n = dtack_sync[SYNC_STAGES-1];
   assign berr_s_n  = berr_sync[SYNC_STAGES-1];

   z3_lane_decode u_lane_decode (
      .siz       (lat_siz),
      .addr_lo   (lat_a),
      .ds_mask_n (lane_mask_n)
   );

   // DTACK_n and BERR_n come straight off the backplane, so both pass through a synchroniser chain.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dtack_sync <= '1;
         berr_sync  <= '1;
      end else begin
         dtack_sync <= {dtack_sync[SYNC_STAGES-2:0], DTACK_n};
         berr_sync  <= {berr_sync[SYNC_STAGES-2:0], BERR_n};
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= Z3M_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The request attributes are captured once when leaving IDLE and held for the whole cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lat_read <= 1'b1;
         lat_siz  <= SIZ_LONG;
         lat_a    <= 2'b00;
      end else if (state == Z3M_IDLE && start) begin
         lat_read <= NCR_READ;
         lat_siz  <= NCR_SIZ;
         lat_a    <= NCR_A;
      end
   end

   // Both counters sit at zero outside their state; the wait counter saturates instead of wrapping.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         setup_cnt <= 2'd0;
         wait_cnt  <= 8'd0;
      end else begin
         setup_cnt <= (state == Z3M_ADDR) ? setup_cnt + 2'd1 : 2'd0;
         if (state != Z3M_WAIT) begin
            wait_cnt <= 8'd0;
         end else if (wait_cnt != 8'(TIMEOUT)) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end

   // Next state and Moore outputs; wait_cnt counts completed WAIT cycles, so the abort decision
   // is taken in the cycle that brings the count to TIMEOUT.
   always_comb begin
      state_next  = state;
      ADDR_OE     = 1'b0;
      ZFCS_n      = 1'b1;
      ZREAD       = 1'b1;
      ZDOE        = 1'b0;
      ZDS_n       = 4'hF;
      NCR_STERM_n = 1'b1;
      NCR_BERR_n  = 1'b1;
      busy        = (state != Z3M_IDLE);
      unique case (state)
         Z3M_IDLE: begin
            if (start) state_next = Z3M_ADDR;
         end
         Z3M_ADDR: begin
            ADDR_OE = 1'b1;
            ZREAD   = lat_read;
            if (setup_cnt == 2'(ADDR_SETUP - 1)) state_next = Z3M_FCS;
         end
         Z3M_FCS: begin
            ADDR_OE    = 1'b1;
            ZREAD      = lat_read;
            ZFCS_n     = 1'b0;
            state_next = Z3M_DATA;
         end
         Z3M_DATA: begin
            ADDR_OE    = 1'b1;
            ZREAD      = lat_read;
            ZFCS_n     = 1'b0;
            ZDOE       = 1'b1;
            ZDS_n      = lane_mask_n;
            state_next = Z3M_WAIT;
         end
         Z3M_WAIT: begin
            ADDR_OE = 1'b1;
            ZREAD   = lat_read;
            ZFCS_n  = 1'b0;
            ZDOE    = 1'b1;
            ZDS_n   = lane_mask_n;
            if (!berr_s_n) begin
               state_next = Z3M_ABORT;
            end else if (!dtack_s_n) begin
               state_next = Z3M_TERM;
            end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
               state_next = Z3M_ABORT;
            end
         end
         Z3M_TERM: begin
            ADDR_OE     = 1'b1;
            ZREAD       = lat_read;
            NCR_STERM_n = 1'b0;
            state_next  = Z3M_RECOVER;
         end
         Z3M_ABORT: begin
            ADDR_OE    = 1'b1;
            ZREAD      = lat_read;
            NCR_BERR_n = 1'b0;
            state_next = Z3M_RECOVER;
         end
         Z3M_RECOVER: begin
            if (dtack_s_n && berr_s_n && NCR_AS_n) state_next = Z3M_IDLE;
         end
         default: begin
            state_next = Z3M_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_z3_master_cycle.sv
// Scoreboard bench for z3_master_cycle: a driver plays NCR and Zorro slave, a monitor checks lanes and terminations.
module tb_z3_master_cycle;

   typedef struct {
      logic [3:0] lanes;
      logic       read;
      logic       berr;
      int         strobeCycles;
   } expTxn_t;

   localparam logic [10:0] RESET_VEC = 11'b0_1_1_0_1111_1_1_0;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       BMASTER = 1'b1;
   logic       NCR_AS_n = 1'b1;
   logic       NCR_READ = 1'b1;
   logic [1:0] NCR_SIZ = 2'b00;
   logic [1:0] NCR_A = 2'b00;
   logic       DTACK_n = 1'b1;
   logic       BERR_n = 1'b1;
   logic       ADDR_OE;
   logic       ZFCS_n;
   logic       ZREAD;
   logic       ZDOE;
   logic [3:0] ZDS_n;
   logic       NCR_STERM_n;
   logic       NCR_BERR_n;
   logic       busy;

   int errors = 0;
   int checks = 0;
   expTxn_t scoreboard[$];

   z3_master_cycle dut (
      .CLK         (CLK),
      .RST         (RST),
      .BMASTER     (BMASTER),
      .NCR_AS_n    (NCR_AS_n),
      .NCR_READ    (NCR_READ),
      .NCR_SIZ     (NCR_SIZ),
      .NCR_A       (NCR_A),
      .DTACK_n     (DTACK_n),
      .BERR_n      (BERR_n),
      .ADDR_OE     (ADDR_OE),
      .ZFCS_n      (ZFCS_n),
      .ZREAD       (ZREAD),
      .ZDOE        (ZDOE),
      .ZDS_n       (ZDS_n),
      .NCR_STERM_n (NCR_STERM_n),
      .NCR_BERR_n  (NCR_BERR_n),
      .busy        (busy)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // mode 0: DTACK only, 1: DTACK and BERR together, 2: no response (timeout)
   task automatic applyStimulus(input logic rd, input logic [1:0] siz, input logic [1:0] a,
                                input logic [3:0] lanes, input int dtackDelay, input int mode);
      expTxn_t t;
      bit seen;
      t.lanes = lanes;
      t.read = rd;
      t.berr = (mode != 0);
      t.strobeCycles = (mode == 2) ? 256 : 0;
      scoreboard.push_back(t);
      @(posedge CLK); #1;
      NCR_READ = rd;
      NCR_SIZ  = siz;
      NCR_A    = a;
      NCR_AS_n = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(posedge CLK); #1;
         if (!ZFCS_n) seen = 1'b1;
      end
      checkOutput("fcs_seen", 32'(seen), 32'd1);
      if (mode != 2) begin
         repeat (dtackDelay) @(posedge CLK);
         #1;
         DTACK_n = 1'b0;
         if (mode == 1) BERR_n = 1'b0;
      end
      seen = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         @(posedge CLK); #1;
         if (!NCR_STERM_n || !NCR_BERR_n) seen = 1'b1;
      end
      checkOutput("term_seen", 32'(seen), 32'd1);
      DTACK_n = 1'b1;
      BERR_n  = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      checkOutput("recover_hold", 32'(busy), 32'd1);
      NCR_AS_n = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(posedge CLK); #1;
         if (!busy) seen = 1'b1;
      end
      checkOutput("idle_seen", 32'(seen), 32'd1);
   endtask

   // Monitor: checks lanes at the strobe edge, pops the scoreboard on each NCR termination.
   initial begin : monitor
      logic    prevDoe;
      int      strobeCycles;
      expTxn_t e;
      prevDoe = 1'b0;
      strobeCycles = 0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            prevDoe = 1'b0;
            strobeCycles = 0;
            continue;
         end
         if (ZDOE && !prevDoe) begin
            if (scoreboard.size() == 0) begin
               checkOutput("unexpected_cycle", 32'd1, 32'd0);
            end else begin
               checkOutput("lanes", 32'(ZDS_n), 32'(scoreboard[0].lanes));
               checkOutput("zread", 32'(ZREAD), 32'(scoreboard[0].read));
            end
         end
         if (ZDOE) strobeCycles++;
         prevDoe = ZDOE;
         if (!NCR_STERM_n || !NCR_BERR_n) begin
            if (scoreboard.size() == 0) begin
               checkOutput("unexpected_term", 32'd1, 32'd0);
            end else begin
               e = scoreboard.pop_front();
               checkOutput("term_kind", 32'({NCR_BERR_n, NCR_STERM_n}), e.berr ? 32'd1 : 32'd2);
               checkOutput("term_strobes", 32'({ZFCS_n, ZDOE, ZDS_n}), 32'b10_1111);
               if (e.strobeCycles != 0) checkOutput("strobe_cycles", 32'(strobeCycles), 32'(e.strobeCycles));
            end
            strobeCycles = 0;
            @(negedge CLK);
            checkOutput("term_width", 32'({NCR_BERR_n, NCR_STERM_n}), 32'd3);
         end
      end
   end

   initial begin : watchdog
      #500_000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      bit seen;
      #1 RST = 1'b1;
      #1 checkOutput("reset_state", 32'({ADDR_OE, ZFCS_n, ZREAD, ZDOE, ZDS_n, NCR_STERM_n, NCR_BERR_n, busy}),
                     32'(RESET_VEC));
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;

      applyStimulus(1'b1, 2'b00, 2'b00, 4'b0000, 4, 0);
      applyStimulus(1'b0, 2'b01, 2'b11, 4'b1110, 1, 0);
      applyStimulus(1'b1, 2'b10, 2'b11, 4'b1110, 0, 0);
      applyStimulus(1'b0, 2'b11, 2'b01, 4'b1000, 2, 0);
      applyStimulus(1'b0, 2'b10, 2'b00, 4'b0011, 3, 0);
      applyStimulus(1'b1, 2'b01, 2'b01, 4'b1011, 0, 0);
      applyStimulus(1'b1, 2'b00, 2'b10, 4'b1100, 5, 0);
      applyStimulus(1'b0, 2'b11, 2'b00, 4'b0001, 1, 0);
      applyStimulus(1'b1, 2'b00, 2'b00, 4'b0000, 2, 1);
      applyStimulus(1'b0, 2'b01, 2'b00, 4'b0111, 0, 2);

      // Reset in the middle of a WAIT: outputs must snap back before the next clock edge.
      begin
         expTxn_t t;
         t.lanes = 4'b0000;
         t.read = 1'b1;
         t.berr = 1'b0;
         t.strobeCycles = 0;
         scoreboard.push_back(t);
      end
      @(posedge CLK); #1;
      NCR_READ = 1'b1;
      NCR_SIZ  = 2'b00;
      NCR_A    = 2'b00;
      NCR_AS_n = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(posedge CLK); #1;
         if (ZDOE) seen = 1'b1;
      end
      checkOutput("doe_seen", 32'(seen), 32'd1);
      repeat (5) @(posedge CLK);
      #2 RST = 1'b1;
      #1 checkOutput("reset_async", 32'({ADDR_OE, ZFCS_n, ZREAD, ZDOE, ZDS_n, NCR_STERM_n, NCR_BERR_n, busy}),
                     32'(RESET_VEC));
      scoreboard.delete();
      NCR_AS_n = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      repeat (3) @(posedge CLK);

      // No grant: a pending request must not start a cycle.
      #1;
      BMASTER  = 1'b0;
      NCR_AS_n = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(posedge CLK); #1;
         checkOutput("no_grant", 32'({ZFCS_n, busy}), 32'd2);
      end
      NCR_AS_n = 1'b1;
      BMASTER  = 1'b1;

      applyStimulus(1'b0, 2'b10, 2'b10, 4'b1100, 1, 0);

      repeat (3) @(posedge CLK);
      checkOutput("sb_empty", 32'(scoreboard.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
